// File: rtl/carregador_pkg.sv
// rtl/carregador_pkg.sv - shared states, block geometry defaults and control codes for the program loader
package carregador_pkg;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    PEDE   = 3'd1,
    ESPERA = 3'd2,
    GRAVA  = 3'd3,
    FIM    = 3'd4
  } estado_t;

  localparam int unsigned TAM_BLOCO_PADRAO = 200;
  localparam int unsigned NUM_PROC_PADRAO  = 10;

  localparam logic [1:0] SALVA       = 2'b01;
  localparam logic [1:0] NADA        = 2'b00;
  localparam logic [1:0] FIM_LEITURA = 2'b01;

endpackage

// File: rtl/carregador_programa.sv
// rtl/carregador_programa.sv - streams a program from the HD into one process block of instruction memory
module carregador_programa
  import carregador_pkg::*;
#(
  parameter int unsigned TAM_BLOCO = TAM_BLOCO_PADRAO,
  parameter int unsigned NUM_PROC  = NUM_PROC_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [3:0]  numProcesso,
  input  logic [31:0] trilhaHD,
  input  logic [7:0]  tamPrograma,
  output logic        leHD,
  output logic [31:0] enderecoHD,
  input  logic [31:0] dadoHD,
  input  logic        hdValido,
  output logic [31:0] entradaDeInstrucao,
  output logic [31:0] enderecoInstrucao,
  output logic [1:0]  controleSalvaInstrucao,
  output logic [1:0]  ControleFimDeLeitura,
  output logic        ocupado,
  output logic        erro
);

  estado_t     estado_q, estado_d;
  logic [7:0]  offset_q, offset_d;
  logic [7:0]  tam_q, tam_d;
  logic [31:0] trilha_q, trilha_d;
  logic [31:0] base_q, base_d;
  logic [31:0] dado_q, dado_d;

  logic        le_hd_q, le_hd_d;
  logic [31:0] end_hd_q, end_hd_d;
  logic [31:0] entrada_q, entrada_d;
  logic [31:0] end_instr_q, end_instr_d;
  logic [1:0]  salva_q, salva_d;
  logic [1:0]  fim_q, fim_d;
  logic        ocupado_q, ocupado_d;
  logic        erro_q, erro_d;

  logic        partida;
  logic        parametro_ruim;
  logic [7:0]  offset_inc;

  // Outputs are registered from the current state, so they trail the state by one cycle
  // and stay stable across the negedge where the instruction memory samples them.
  always_comb begin
    partida        = iniciar && (estado_q == OCIOSO) && !ocupado_q;
    parametro_ruim = (tamPrograma == 8'd0)
                  || (32'(tamPrograma) > TAM_BLOCO)
                  || (32'(numProcesso) >= NUM_PROC);
    offset_inc     = offset_q + 8'd1;

    estado_d    = estado_q;
    offset_d    = offset_q;
    tam_d       = tam_q;
    trilha_d    = trilha_q;
    base_d      = base_q;
    dado_d      = dado_q;
    le_hd_d     = 1'b0;
    end_hd_d    = end_hd_q;
    entrada_d   = entrada_q;
    end_instr_d = end_instr_q;
    salva_d     = NADA;
    fim_d       = NADA;
    ocupado_d   = (estado_q != OCIOSO);
    erro_d      = erro_q;

    case (estado_q)
      OCIOSO: begin
        if (partida) begin
          trilha_d = trilhaHD;
          tam_d    = tamPrograma;
          base_d   = 32'(numProcesso) * TAM_BLOCO;
          offset_d = 8'd0;
          erro_d   = parametro_ruim;
          if (!parametro_ruim) estado_d = PEDE;
        end
      end
      PEDE: begin
        le_hd_d  = 1'b1;
        end_hd_d = trilha_q + 32'(offset_q);
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (hdValido) begin
          dado_d   = dadoHD;
          estado_d = GRAVA;
        end
      end
      GRAVA: begin
        salva_d     = SALVA;
        entrada_d   = dado_q;
        end_instr_d = base_q + 32'(offset_q);
        offset_d    = offset_inc;
        estado_d    = (offset_inc == tam_q) ? FIM : PEDE;
      end
      FIM: begin
        fim_d    = FIM_LEITURA;
        offset_d = 8'd0;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= OCIOSO;
      offset_q    <= 8'd0;
      tam_q       <= 8'd0;
      trilha_q    <= 32'd0;
      base_q      <= 32'd0;
      dado_q      <= 32'd0;
      le_hd_q     <= 1'b0;
      end_hd_q    <= 32'd0;
      entrada_q   <= 32'd0;
      end_instr_q <= 32'd0;
      salva_q     <= NADA;
      fim_q       <= NADA;
      ocupado_q   <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      offset_q    <= offset_d;
      tam_q       <= tam_d;
      trilha_q    <= trilha_d;
      base_q      <= base_d;
      dado_q      <= dado_d;
      le_hd_q     <= le_hd_d;
      end_hd_q    <= end_hd_d;
      entrada_q   <= entrada_d;
      end_instr_q <= end_instr_d;
      salva_q     <= salva_d;
      fim_q       <= fim_d;
      ocupado_q   <= ocupado_d;
      erro_q      <= erro_d;
    end
  end

  assign leHD                   = le_hd_q;
  assign enderecoHD             = end_hd_q;
  assign entradaDeInstrucao     = entrada_q;
  assign enderecoInstrucao      = end_instr_q;
  assign controleSalvaInstrucao = salva_q;
  assign ControleFimDeLeitura   = fim_q;
  assign ocupado                = ocupado_q;
  assign erro                   = erro_q;

endmodule

// File: tb/tb_carregador_programa.sv
// tb/tb_carregador_programa.sv - randomized scoreboard bench for carregador_programa with an HD responder model
module tb_carregador_programa;

  logic        clock;
  logic        reset;
  logic        iniciar;
  logic [3:0]  numProcesso;
  logic [31:0] trilhaHD;
  logic [7:0]  tamPrograma;
  logic        leHD;
  logic [31:0] enderecoHD;
  logic [31:0] dadoHD;
  logic        hdValido;
  logic [31:0] entradaDeInstrucao;
  logic [31:0] enderecoInstrucao;
  logic [1:0]  controleSalvaInstrucao;
  logic [1:0]  ControleFimDeLeitura;
  logic        ocupado;
  logic        erro;

  carregador_programa dut (
    .clock                 (clock),
    .reset                 (reset),
    .iniciar               (iniciar),
    .numProcesso           (numProcesso),
    .trilhaHD              (trilhaHD),
    .tamPrograma           (tamPrograma),
    .leHD                  (leHD),
    .enderecoHD            (enderecoHD),
    .dadoHD                (dadoHD),
    .hdValido              (hdValido),
    .entradaDeInstrucao    (entradaDeInstrucao),
    .enderecoInstrucao     (enderecoInstrucao),
    .controleSalvaInstrucao(controleSalvaInstrucao),
    .ControleFimDeLeitura  (ControleFimDeLeitura),
    .ocupado               (ocupado),
    .erro                  (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e_mon;
  int          vectors = 0;
  int          miscompares = 0;
  int          writes_seen = 0;
  int          fim_seen = 0;
  int          le_seen = 0;
  int          req_base = 0;
  int          lat_word = -1;
  bit          rand_lat = 0;
  bit          spur_en = 0;
  logic [31:0] last_wr_addr = 32'd0;
  logic [31:0] salt;

  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'd0;

  function automatic logic [31:0] hd_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // HD responder: answers each read request after a chosen latency; may inject stray hdValido.
  always @(negedge clock) begin
    hdValido = 1'b0;
    if (!reset) begin
      pend = 1'b0;
    end else begin
      if (leHD) begin
        le_seen++;
        pend      = 1'b1;
        pend_addr = enderecoHD;
        if (le_seen - req_base == lat_word) cnt = 5;
        else if (rand_lat)                  cnt = int'($urandom_range(0, 3));
        else                                cnt = 0;
      end
      if (pend) begin
        if (cnt == 0) begin
          hdValido = 1'b1;
          dadoHD   = hd_word(pend_addr);
          pend     = 1'b0;
        end else begin
          cnt--;
        end
      end else if (spur_en && controleSalvaInstrucao == 2'b01) begin
        hdValido = 1'b1;
        dadoHD   = ~salt;
      end
    end
  end

  // Monitor: every write presented to instruction memory is popped against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      if (controleSalvaInstrucao == 2'b01) begin
        writes_seen++;
        last_wr_addr = enderecoInstrucao;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %0h expected no write", enderecoInstrucao);
        end else begin
          e_mon = exp_q.pop_front();
          chk("wr_addr", enderecoInstrucao, e_mon.addr);
          chk("wr_data", entradaDeInstrucao, e_mon.data);
        end
      end
      if (ControleFimDeLeitura == 2'b01) begin
        fim_seen++;
        if (controleSalvaInstrucao == 2'b01) chk("salva_fim_overlap", 32'd1, 32'd0);
      end
    end
  end

  task automatic run_load(input logic [3:0] np, input logic [31:0] tr, input logic [7:0] tam,
                          input int lw, input bit rl, input bit spur, input bit timed);
    int  w0, f0, l0, cyc;
    bit  bad, seen_busy;
    wr_t e;
    bad = (tam == 8'd0) || (tam > 8'd200) || (np >= 4'd10);
    cyc = 0;
    while (ocupado && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
    lat_word = lw;
    rand_lat = rl;
    spur_en  = spur;
    req_base = le_seen;
    w0 = writes_seen; f0 = fim_seen; l0 = le_seen;
    if (!bad) begin
      for (int i = 0; i < int'(tam); i++) begin
        e.addr = 32'(np) * 32'd200 + 32'(i);
        e.data = hd_word(tr + 32'(i));
        exp_q.push_back(e);
      end
    end
    numProcesso = np; trilhaHD = tr; tamPrograma = tam; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    numProcesso = 4'($urandom); trilhaHD = $urandom; tamPrograma = 8'($urandom);
    cyc = 1;
    if (bad) begin
      seen_busy = 1'b0;
      repeat (5) begin
        if (ocupado) seen_busy = 1'b1;
        @(negedge clock);
      end
      chk("bad_erro", 32'(erro), 32'd1);
      chk("bad_busy", 32'(seen_busy), 32'd0);
      chk("bad_writes", 32'(writes_seen - w0), 32'd0);
      chk("bad_le", 32'(le_seen - l0), 32'd0);
    end else begin
      while (!ocupado && cyc < 10) begin
        @(negedge clock);
        cyc++;
      end
      while (ocupado && cyc < 3000) begin
        iniciar = spur && (controleSalvaInstrucao == 2'b01);
        @(negedge clock);
        cyc++;
      end
      iniciar = 1'b0;
      if (cyc >= 3000) chk("busy_timeout", 32'(cyc), 32'd0);
      if (timed) chk("duration", 32'(cyc - 1), 32'(3 * int'(tam) + 2));
      repeat (2) @(negedge clock);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("fim_pulses", 32'(fim_seen - f0), 32'd1);
      chk("le_pulses", 32'(le_seen - l0), 32'(tam));
      chk("write_count", 32'(writes_seen - w0), 32'(tam));
      chk("erro_clear", 32'(erro), 32'd0);
    end
    spur_en = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_leHD"}, 32'(leHD), 32'd0);
    chk({tag, "_enderecoHD"}, enderecoHD, 32'd0);
    chk({tag, "_entrada"}, entradaDeInstrucao, 32'd0);
    chk({tag, "_endInstr"}, enderecoInstrucao, 32'd0);
    chk({tag, "_salva"}, 32'(controleSalvaInstrucao), 32'd0);
    chk({tag, "_fim"}, 32'(ControleFimDeLeitura), 32'd0);
    chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
    chk({tag, "_erro"}, 32'(erro), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w0, f0, k;
    wr_t  e;
    salt = $urandom;
    reset = 1'b0; iniciar = 1'b0; numProcesso = 4'd0; trilhaHD = 32'd0; tamPrograma = 8'd0;
    dadoHD = 32'd0;
    repeat (3) @(negedge clock);
    chk_outputs_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    run_load(4'd2, 32'd100, 8'd3, -1, 1'b0, 1'b0, 1'b1);
    chk("normal_last_addr", last_wr_addr, 32'd402);

    run_load(4'd3, 32'd500, 8'd4, 2, 1'b0, 1'b0, 1'b0);

    run_load(4'd4, 32'd10, 8'd0, -1, 1'b0, 1'b0, 1'b0);
    run_load(4'd4, 32'd10, 8'd201, -1, 1'b0, 1'b0, 1'b0);
    run_load(4'd10, 32'd10, 8'd5, -1, 1'b0, 1'b0, 1'b0);
    run_load(4'd1, 32'd7, 8'd2, -1, 1'b0, 1'b0, 1'b1);

    run_load(4'd9, $urandom, 8'd200, -1, 1'b1, 1'b0, 1'b0);
    chk("full_last_addr", last_wr_addr, 32'd1999);

    // Reset during the write cycle of the second word of a five-word load.
    lat_word = -1; rand_lat = 1'b0; spur_en = 1'b0; req_base = le_seen;
    w0 = writes_seen; f0 = fim_seen;
    for (int i = 0; i < 5; i++) begin
      e.addr = 32'd200 + 32'(i);
      e.data = hd_word(32'd50 + 32'(i));
      exp_q.push_back(e);
    end
    numProcesso = 4'd1; trilhaHD = 32'd50; tamPrograma = 8'd5; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    k = 0;
    while (controleSalvaInstrucao != 2'b01 && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (k >= 50) chk("first_write_timeout", 32'(k), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 chk_outputs_zero("midreset");
    exp_q.delete();
    repeat (3) @(negedge clock);
    chk("midreset_writes", 32'(writes_seen - w0), 32'd1);
    chk("midreset_fim", 32'(fim_seen - f0), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    run_load(4'd1, 32'd50, 8'd5, -1, 1'b0, 1'b0, 1'b1);

    run_load(4'd5, 32'd1000, 8'd6, -1, 1'b0, 1'b1, 1'b1);

    run_load(4'd7, 32'hFFFF_FFFE, 8'd4, -1, 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      run_load(4'($urandom_range(0, 9)), $urandom, 8'($urandom_range(1, 20)),
               -1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Streams a program from the HD into the instruction memory. A program of `tamPrograma` words is read from HD address `trilhaHD`. Each word is written into the instruction memory block of process `numProcesso`, at base `numProcesso*TAM_BLOCO`. The block drives the instruction memory's `entradaDeInstrucao` / `controleSalvaInstrucao` / `ControleFimDeLeitura` load port, and the SO triggers it when a process is created.

## Interface
- `TAM_BLOCO`, 200: words per process block in instruction memory.
- `NUM_PROC`, 10: number of process slots; slot 0 is the SO.
- `clock`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low; state and outputs cleared while low.
- `iniciar`  in  1  start request; sampled only in OCIOSO.
- `numProcesso`  in  4  destination slot; latched at start.
- `trilhaHD`  in  32  HD word address of the program's first word; latched at start.
- `tamPrograma`  in  8  program length in words; latched at start.
- `leHD`  out  1  HD read request.
- `enderecoHD`  out  32  HD read address.
- `dadoHD`  in  32  HD read data.
- `hdValido`  in  1  `dadoHD` valid; meaningful only in ESPERA.
- `entradaDeInstrucao`  out  32  word to write into instruction memory.
- `enderecoInstrucao`  out  32  instruction memory write address.
- `controleSalvaInstrucao`  out  2  2'b01 = write this cycle, 2'b00 = idle.
- `ControleFimDeLeitura`  out  2  2'b01 for one cycle after the last write.
- `ocupado`  out  1  high in every state except OCIOSO.
- `erro`  out  1  sticky parameter error; cleared by the next accepted `iniciar`.

## Operation
- **Reset values:** all outputs 0, state OCIOSO, offset counter 0.
- **Start validation:** on `iniciar` in OCIOSO, latch the inputs, compute `base = numProcesso*TAM_BLOCO` (32-bit) and clear `erro`.
  - If `tamPrograma==0`, `tamPrograma>TAM_BLOCO` or `numProcesso>=NUM_PROC`: set `erro`, stay in OCIOSO, perform no HD access and no write.
  - Otherwise go to PEDE.
- **States:**
  - OCIOSO: wait for a valid start (see above).
  - PEDE: `leHD=1`, `enderecoHD=trilhaHD+offset` (32-bit wrap); go to ESPERA.
  - ESPERA: `leHD=0`; wait indefinitely for `hdValido`. On `hdValido`, capture `dadoHD` and go to GRAVA.
  - GRAVA: `controleSalvaInstrucao=2'b01`, `entradaDeInstrucao`=captured word, `enderecoInstrucao=base+offset`; increment offset. If the new offset equals `tamPrograma`, go to FIM; otherwise go to PEDE.
  - FIM: `ControleFimDeLeitura=2'b01`, then OCIOSO with offset cleared.
- **Ignored inputs:**
  - `iniciar` while `ocupado` is ignored.
  - `hdValido` outside ESPERA is ignored.
  - Input changes after start are ignored.
- **Reset mid-transfer:** return to OCIOSO immediately. No end pulse is issued; words already written stay in memory.
- **Output stability:** `controleSalvaInstrucao` and `ControleFimDeLeitura` are never 2'b01 in the same cycle.

## Timing
- All outputs are registered off posedge. This keeps them stable across the negedge where instruction memory samples them.
- Per word: PEDE 1 cycle + ESPERA ≥1 cycle + GRAVA 1 cycle, so minimum 3 cycles/word when `hdValido` arrives in the first ESPERA cycle.
- Start to first `leHD`: 1 cycle. Last write to `ControleFimDeLeitura`: 1 cycle. End pulse to `ocupado` low: 1 cycle.
- Full transfer of N words with zero HD wait: 3N+2 cycles from accepted `iniciar` to `ocupado` low.
- `enderecoInstrucao` increases by exactly 1 per write, starting at `base`, with no gaps.

## Structure
- Shared package `carregador_pkg` holds:
  - the state enum (OCIOSO, PEDE, ESPERA, GRAVA, FIM);
  - `TAM_BLOCO` and `NUM_PROC` defaults;
  - control codes `SALVA=2'b01`, `NADA=2'b00`, `FIM_LEITURA=2'b01`.
- No sub-module: the constant multiply, the offset counter and the FSM stay in one module.

## Test plan
- **Normal load:** `numProcesso=2`, `trilhaHD=100`, `tamPrograma=3`, HD answers next cycle. Expect:
  - writes to 400, 401, 402 with HD words 100–102;
  - one end pulse;
  - `ocupado` low after 11 cycles.
- **HD latency:** `hdValido` delayed 5 cycles on word 2 → `leHD` pulses once per word, no extra writes, data correct.
- **Bad parameters:** `tamPrograma=0`, then 201, then `numProcesso=10` → `erro=1` each time; no `leHD`, no write, `ocupado` stays 0. A following valid start clears `erro`.
- **Full block:** `numProcesso=9`, `tamPrograma=200` → last write at address 1999; `ControleFimDeLeitura` pulses exactly once.
- **Reset mid-transfer:** `reset` low during GRAVA of word 1 of 5 → all outputs 0 asynchronously; no end pulse. A restart rewrites from the block base.
- **Spurious inputs:** `iniciar` and `hdValido` pulsed while busy (outside ESPERA) → ignored; transfer result unchanged.
